// File: rtl/key_pkg.sv
// Shared types and board defaults for the key debouncer.
//   key_state_t : per-channel debounce FSM state
//   DEF_*       : default timing for a 50 MHz board clock
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned DEF_N_KEYS          = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchronizer, debounce FSM, auto-repeat timer.
//   clk, rst_n   : clock, async active-low reset
//   key          : raw pin, active-low, asynchronous to clk
//   held         : debounced level, 1 = pressed
//   pressed      : 1-cycle pulse on accepted press
//   released     : 1-cycle pulse on accepted release
//   repeat_pulse : 1-cycle auto-repeat pulse while held
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic held,
  output logic pressed,
  output logic released,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER   = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_SAT   = RPT_W'(RPT_MAX);

  logic [1:0]       sync_q;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             armed_q, armed_d;  // first repeat already fired since entry

  logic s_c;
  logic held_c, pressed_c, released_c, rpt_hit_c, fire_c;

  // Synced pin, flipped to active-high
  assign s_c = ~sync_q[1];

  // Registers: synchronizer, FSM, counters, outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= RELEASED;
      cnt_q        <= '0;
      rpt_q        <= '0;
      armed_q      <= 1'b0;
      held         <= 1'b0;
      pressed      <= 1'b0;
      released     <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], key};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rpt_q        <= rpt_d;
      armed_q      <= armed_d;
      held         <= held_c;
      pressed      <= pressed_c;
      released     <= released_c;
      repeat_pulse <= fire_c;
    end
  end

  // Next state, counters and output intents
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rpt_d      = rpt_q;
    armed_d    = armed_q;
    held_c     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    pressed_c  = held_c & ~held;
    released_c = ~held_c & held;
    rpt_hit_c  = 1'b0;
    fire_c     = 1'b0;

    // Repeat timer keeps its phase across release glitches; pulses only in a stable PRESSED
    if (REPEAT_PERIOD != 0) begin
      rpt_hit_c = armed_q ? (rpt_q == RPT_PER) : (rpt_q == RPT_DELAY);
    end
    if (held_c) begin
      if (rpt_hit_c) begin
        rpt_d   = RPT_W'(1);
        armed_d = 1'b1;
      end else if (rpt_q != RPT_SAT) begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
    fire_c = rpt_hit_c && (state_q == PRESSED) && s_c;

    unique case (state_q)
      RELEASED: begin
        if (s_c) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = PRESSED;
            rpt_d   = '0;
            armed_d = 1'b0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s_c) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rpt_d   = '0;
          armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s_c) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = RELEASED;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s_c) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: rtl/key_event_debouncer.sv
// Debounces N_KEYS active-low board keys into clean levels and events.
//   clk, rst_n   : clock, async active-low reset
//   key          : raw active-low pins
//   key_held     : debounced levels, 1 = pressed
//   key_pressed  : 1-cycle press events
//   key_released : 1-cycle release events
//   key_repeat   : 1-cycle auto-repeat pulses
module key_event_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = DEF_N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_held,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_released,
  output logic [N_KEYS-1:0] key_repeat
);

  // One independent channel per key
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .key          (key[i]),
      .held         (key_held[i]),
      .pressed      (key_pressed[i]),
      .released     (key_released[i]),
      .repeat_pulse (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_event_debouncer.sv
// Scoreboard bench for key_event_debouncer: a per-cycle reference model pushes
// expected output vectors, a monitor pops and compares them on the falling edge.
module tb_key_event_debouncer;

  localparam int unsigned N   = 3;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key;
  logic [N-1:0] key_held, key_pressed, key_released, key_repeat;

  key_event_debouncer #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .key_held     (key_held),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .key_repeat   (key_repeat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [4*N-1:0] exp_q[$];

  // Reference model: synced input is the pin delayed two edges; the debounced
  // level flips after DEB consecutive disagreeing samples; outputs lag the level by one edge.
  logic [N-1:0] m_d1, m_d2, m_level, m_held;
  int unsigned  m_run[N];
  int unsigned  m_k[N];   // edges spent at pressed level since acceptance

  always @(posedge clk) begin : model
    logic [N-1:0] nh, np, nr, nf;
    logic         s;
    logic         hit;
    cyc++;
    if (!rst_n) begin
      m_d1 = '1; m_d2 = '1; m_level = '0; m_held = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_k[i] = 0; end
      exp_q.push_back('0);
    end else begin
      for (int i = 0; i < N; i++) begin
        s     = ~m_d2[i];
        nh[i] = m_level[i];
        np[i] = m_level[i] & ~m_held[i];
        nr[i] = ~m_level[i] & m_held[i];
        nf[i] = 1'b0;
        if (m_level[i]) begin
          hit = (m_k[i] == RD) || (m_k[i] > RD && ((m_k[i] - RD) % RP) == 0);
          if (hit && m_run[i] == 0 && s) nf[i] = 1'b1;
          m_k[i]++;
        end
        if (s != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_level[i] = s;
            m_run[i]   = 0;
            m_k[i]     = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d2   = m_d1;
      m_d1   = key;
      m_held = nh;
      exp_q.push_back({nh, np, nr, nf});
    end
  end

  // Event bookkeeping for directed timing checks
  int press_cnt[N], rel_cnt[N], press_cyc[N], rel_cyc[N];
  int log_key = 0;
  int rep_log[$];

  always @(negedge clk) begin : monitor
    logic [4*N-1:0] e, a;
    a = {key_held, key_pressed, key_released, key_repeat};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty cycle %0d got %h", cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs cycle %0d got held/press/rel/rpt=%h required %h", cyc, a, e);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (key_pressed[i])  begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (key_released[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
    end
    if (key_repeat[log_key]) rep_log.push_back(cyc);
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic slot();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_log(input int k);
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_cyc[i] = -1; rel_cyc[i] = -1;
    end
    log_key = k;
    rep_log.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e0, e1, elast;
    int r[N];
    int unsigned hold_left[N];

    rst_n = 1'b0;
    key   = '1;
    clear_log(0);
    slot(); slot();
    check("reset_outputs", int'({key_held, key_pressed, key_released, key_repeat}), 0);
    slot(); rst_n = 1'b1;
    repeat (5) slot();

    // 1: clean press of key 0, 8 low samples
    clear_log(0);
    slot(); key[0] = 1'b0; e0 = cyc + 1;
    repeat (7) slot();
    slot(); key[0] = 1'b1;
    repeat (12) slot();
    check("t1_press_latency", press_cyc[0] - e0, 6);
    check("t1_press_count", press_cnt[0], 1);
    check("t1_release_count", rel_cnt[0], 1);
    check("t1_other_keys", press_cnt[1] + press_cnt[2], 0);

    // 2: key 1 bounces then settles low
    clear_log(1);
    slot(); key[1] = 1'b0;
    slot(); key[1] = 1'b1;
    slot(); key[1] = 1'b0;
    slot(); key[1] = 1'b1;
    slot(); key[1] = 1'b0; elast = cyc + 1;
    repeat (12) slot();
    check("t2_press_count", press_cnt[1], 1);
    check("t2_press_latency", press_cyc[1] - elast, 6);
    slot(); key[1] = 1'b1;
    repeat (12) slot();

    // 3: key 2 held 40 cycles past acceptance
    clear_log(2);
    slot(); key[2] = 1'b0; e0 = cyc + 1;
    repeat (42) slot();
    slot(); key[2] = 1'b1;
    repeat (15) slot();
    check("t3_press_latency", press_cyc[2] - e0, 6);
    check("t3_repeat_count", rep_log.size(), 6);
    for (int j = 0; j < 6; j++)
      check("t3_repeat_offset", (j < rep_log.size()) ? rep_log[j] - press_cyc[2] : -1, 10 + 5 * j);
    check("t3_release_count", rel_cnt[2], 1);

    // 4: 2-cycle release glitch while key 0 is held
    clear_log(0);
    slot(); key[0] = 1'b0;
    repeat (20) slot();
    slot(); key[0] = 1'b1;
    slot();
    slot(); key[0] = 1'b0;
    repeat (15) slot();
    check("t4_no_release", rel_cnt[0], 0);
    check("t4_held", int'(key_held[0]), 1);
    slot(); key[0] = 1'b1;
    repeat (14) slot();
    check("t4_repeat_count", rep_log.size(), 5);
    for (int j = 0; j < 5; j++)
      check("t4_repeat_offset", (j < rep_log.size()) ? rep_log[j] - press_cyc[0] : -1, 10 + 5 * j);
    check("t4_release_count", rel_cnt[0], 1);

    // 5: reset mid-debounce on key 0 while key 2 is held
    clear_log(0);
    slot(); key[2] = 1'b0;
    repeat (9) slot();
    slot(); key[0] = 1'b0;
    repeat (4) slot();
    check("t5_key2_held_before", int'(key_held[2]), 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", int'({key_held, key_pressed, key_released, key_repeat}), 0);
    clear_log(0);
    repeat (3) slot();
    rst_n = 1'b1; e1 = cyc + 1;
    repeat (10) slot();
    check("t5_press_count", press_cnt[0], 1);
    check("t5_press_latency", press_cyc[0] - e1, 6);
    slot(); key = '1;
    repeat (12) slot();

    // 6: all keys pressed together, released independently
    clear_log(1);
    slot(); key = '0; e0 = cyc + 1;
    repeat (8) slot();
    for (int i = 0; i < N; i++) check("t6_press_latency", press_cyc[i] - e0, 6);
    slot(); key[0] = 1'b1; r[0] = cyc + 1;
    repeat (3) slot();
    slot(); key[1] = 1'b1; r[1] = cyc + 1;
    repeat (3) slot();
    slot(); key[2] = 1'b1; r[2] = cyc + 1;
    repeat (12) slot();
    for (int i = 0; i < N; i++) begin
      check("t6_release_count", rel_cnt[i], 1);
      check("t6_release_latency", rel_cyc[i] - r[i], 6);
    end

    // Random bouncy traffic with occasional resets, checked by the scoreboard
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      slot();
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          key[i]       = 1'($urandom_range(0, 1));
          hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(8, 40);
        end else begin
          hold_left[i]--;
        end
      end
    end
    slot(); rst_n = 1'b1; key = '1;
    repeat (20) slot();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
